// File: rtl/song_scheduler.sv
// Song table sequencer: walks music ROM addresses per beat,
// with pause, skip, inter-song gaps and end-of-song play modes.
module song_scheduler #(
    parameter int         NUM_SONGS = 4,
    parameter int         GAP_BEATS = 4,
    parameter logic [9:0] S0_START  = 10'd0,
    parameter logic [9:0] S1_START  = 10'd128,
    parameter logic [9:0] S2_START  = 10'd256,
    parameter logic [9:0] S3_START  = 10'd384,
    parameter logic [9:0] S0_END    = 10'd127,
    parameter logic [9:0] S1_END    = 10'd255,
    parameter logic [9:0] S2_END    = 10'd383,
    parameter logic [9:0] S3_END    = 10'd511
) (
    input  logic       ext_clk_25m,
    input  logic       ext_rst,
    input  logic       beat_tick,
    input  logic       play,
    input  logic       stop,
    input  logic       next,
    input  logic [1:0] song_sel,
    input  logic [1:0] mode,
    output logic [9:0] rom_addr,
    output logic [1:0] cur_song,
    output logic       playing,
    output logic       paused,
    output logic       note_en,
    output logic       song_done
);

    typedef enum logic [1:0] {
        IDLE,
        PLAY,
        PAUSE,
        GAP
    } state_t;

    state_t     state;
    logic [3:0] gap_cnt;
    logic [1:0] sel_c;
    logic [1:0] nxt_song;
    logic       last_song;
    logic       at_end;
    logic       gap_last;

    function automatic logic [9:0] start_of(input logic [1:0] s);
        case (s)
            2'd0:    return S0_START;
            2'd1:    return S1_START;
            2'd2:    return S2_START;
            default: return S3_START;
        endcase
    endfunction

    function automatic logic [9:0] end_of(input logic [1:0] s);
        case (s)
            2'd0:    return S0_END;
            2'd1:    return S1_END;
            2'd2:    return S2_END;
            default: return S3_END;
        endcase
    endfunction

    // Selections beyond the table fall back to the first song
    assign sel_c     = ({1'b0, song_sel} >= 3'(NUM_SONGS)) ? 2'd0 : song_sel;
    assign last_song = (cur_song == 2'(NUM_SONGS - 1));
    assign nxt_song  = last_song ? 2'd0 : cur_song + 2'd1;
    assign at_end    = (rom_addr == end_of(cur_song));
    assign gap_last  = (gap_cnt == 4'(GAP_BEATS - 1));
    assign note_en   = beat_tick & (state == PLAY) & ~ext_rst;

    always_ff @(posedge ext_clk_25m) begin
        if (ext_rst) begin
            state     <= IDLE;
            rom_addr  <= S0_START;
            cur_song  <= 2'd0;
            gap_cnt   <= 4'd0;
            playing   <= 1'b0;
            paused    <= 1'b0;
            song_done <= 1'b0;
        end else begin
            song_done <= 1'b0;
            if (stop) begin
                state    <= IDLE;
                playing  <= 1'b0;
                paused   <= 1'b0;
                gap_cnt  <= 4'd0;
                cur_song <= sel_c;
                rom_addr <= start_of(sel_c);
            end else if (next && state != IDLE) begin
                state    <= PLAY;
                playing  <= 1'b1;
                paused   <= 1'b0;
                gap_cnt  <= 4'd0;
                cur_song <= nxt_song;
                rom_addr <= start_of(nxt_song);
            end else begin
                case (state)
                    IDLE: begin
                        cur_song <= sel_c;
                        rom_addr <= start_of(sel_c);
                        if (play) begin
                            state   <= PLAY;
                            playing <= 1'b1;
                        end
                    end
                    PLAY: begin
                        if (play) begin
                            state   <= PAUSE;
                            playing <= 1'b0;
                            paused  <= 1'b1;
                        end else if (beat_tick) begin
                            if (at_end) begin
                                state     <= GAP;
                                playing   <= 1'b0;
                                song_done <= 1'b1;
                                gap_cnt   <= 4'd0;
                            end else begin
                                rom_addr <= rom_addr + 10'd1;
                            end
                        end
                    end
                    PAUSE: begin
                        if (play) begin
                            state   <= PLAY;
                            playing <= 1'b1;
                            paused  <= 1'b0;
                        end
                    end
                    GAP: begin
                        if (beat_tick) begin
                            if (!gap_last) begin
                                gap_cnt <= gap_cnt + 4'd1;
                            end else begin
                                gap_cnt <= 4'd0;
                                // Mode is only consulted here, at end of gap
                                case (mode)
                                    2'b00: begin
                                        state    <= IDLE;
                                        cur_song <= sel_c;
                                        rom_addr <= start_of(sel_c);
                                    end
                                    2'b01: begin
                                        state    <= PLAY;
                                        playing  <= 1'b1;
                                        rom_addr <= start_of(cur_song);
                                    end
                                    2'b10: begin
                                        if (last_song) begin
                                            state    <= IDLE;
                                            cur_song <= sel_c;
                                            rom_addr <= start_of(sel_c);
                                        end else begin
                                            state    <= PLAY;
                                            playing  <= 1'b1;
                                            cur_song <= nxt_song;
                                            rom_addr <= start_of(nxt_song);
                                        end
                                    end
                                    default: begin
                                        state    <= PLAY;
                                        playing  <= 1'b1;
                                        cur_song <= nxt_song;
                                        rom_addr <= start_of(nxt_song);
                                    end
                                endcase
                            end
                        end
                    end
                    default: state <= IDLE;
                endcase
            end
        end
    end

endmodule

// File: tb/tb_song_scheduler.sv
// Scoreboard bench for song_scheduler: two short songs, two-beat gap.
module tb_song_scheduler;

    typedef struct packed {
        logic       beat;
        logic       ply;
        logic       stp;
        logic       nxt;
        logic       rst;
        logic [1:0] sel;
        logic [1:0] md;
    } stim_t;

    typedef struct packed {
        logic [9:0] addr;
        logic [1:0] song;
        logic       playing;
        logic       paused;
        logic       done;
        logic       note;
    } obs_t;

    logic       clk = 1'b0;
    logic       ext_rst = 1'b0;
    logic       beat_tick = 1'b0;
    logic       play = 1'b0;
    logic       stop = 1'b0;
    logic       next = 1'b0;
    logic [1:0] song_sel = 2'd0;
    logic [1:0] mode = 2'd0;
    logic [9:0] rom_addr;
    logic [1:0] cur_song;
    logic       playing;
    logic       paused;
    logic       note_en;
    logic       song_done;

    int compared = 0;
    int mismatched = 0;
    logic [1:0] sel_v = 2'd0;
    logic [1:0] mode_v = 2'd0;
    stim_t stim_q[$];
    obs_t  exp_q[$];
    obs_t  got;
    obs_t  want;
    int    step;

    always #5 clk = ~clk;

    song_scheduler #(
        .NUM_SONGS(2),
        .GAP_BEATS(2),
        .S0_START(10'd0),
        .S0_END(10'd3),
        .S1_START(10'd16),
        .S1_END(10'd17)
    ) dut (
        .ext_clk_25m(clk),
        .ext_rst(ext_rst),
        .beat_tick(beat_tick),
        .play(play),
        .stop(stop),
        .next(next),
        .song_sel(song_sel),
        .mode(mode),
        .rom_addr(rom_addr),
        .cur_song(cur_song),
        .playing(playing),
        .paused(paused),
        .note_en(note_en),
        .song_done(song_done)
    );

    // Queue one cycle of stimulus with the outputs it must produce
    function automatic void push(input logic b, input logic p,
                                 input logic st, input logic n,
                                 input logic r, input int a, input int s,
                                 input logic pl, input logic pa,
                                 input logic d, input logic ne);
        stim_q.push_back('{b, p, st, n, r, sel_v, mode_v});
        exp_q.push_back('{10'(a), 2'(s), pl, pa, d, ne});
    endfunction

    task automatic apply(input stim_t st, output obs_t o);
        @(negedge clk);
        beat_tick = st.beat;
        play      = st.ply;
        stop      = st.stp;
        next      = st.nxt;
        ext_rst   = st.rst;
        song_sel  = st.sel;
        mode      = st.md;
        #1;
        o.note = note_en;
        @(posedge clk);
        #1;
        o.addr    = rom_addr;
        o.song    = cur_song;
        o.playing = playing;
        o.paused  = paused;
        o.done    = song_done;
    endtask

    task automatic test_reset;
        sel_v = 2'd0; mode_v = 2'd0;
        push(0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        push(1, 1, 0, 1, 1, 0, 0, 0, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sel_v = 2'd1;
        push(0, 0, 0, 0, 0, 16, 1, 0, 0, 0, 0);
        sel_v = 2'd3;
        push(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sel_v = 2'd0;
        push(0, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step = 0;
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front(), got);
            want = exp_q.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL reset[%0d]: got %p want %p", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_single;
        sel_v = 2'd0; mode_v = 2'd0;
        push(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        push(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
        push(0, 0, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        push(1, 0, 0, 0, 0, 2, 0, 1, 0, 0, 1);
        push(1, 0, 0, 0, 0, 3, 0, 1, 0, 0, 1);
        push(1, 0, 0, 0, 0, 3, 0, 0, 0, 1, 1);
        push(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        step = 0;
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front(), got);
            want = exp_q.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL single[%0d]: got %p want %p", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_loop;
        sel_v = 2'd1; mode_v = 2'd3;
        push(0, 0, 0, 0, 0, 16, 1, 0, 0, 0, 0);
        push(0, 1, 0, 0, 0, 16, 1, 1, 0, 0, 0);
        push(1, 0, 0, 0, 0, 17, 1, 1, 0, 0, 1);
        push(1, 0, 0, 0, 0, 17, 1, 0, 0, 1, 1);
        push(1, 0, 0, 0, 0, 17, 1, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step = 0;
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front(), got);
            want = exp_q.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL loop[%0d]: got %p want %p", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_pause;
        push(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
        push(1, 1, 0, 0, 0, 1, 0, 0, 1, 0, 1);
        push(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        push(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        push(1, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0);
        push(0, 1, 0, 0, 0, 1, 0, 1, 0, 0, 0);
        push(1, 0, 0, 0, 0, 2, 0, 1, 0, 0, 1);
        step = 0;
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front(), got);
            want = exp_q.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL pause[%0d]: got %p want %p", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_next;
        push(0, 0, 0, 1, 0, 16, 1, 1, 0, 0, 0);
        push(1, 0, 0, 0, 0, 17, 1, 1, 0, 0, 1);
        push(1, 0, 0, 0, 0, 17, 1, 0, 0, 1, 1);
        push(0, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0);
        push(0, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        push(0, 1, 0, 0, 0, 0, 0, 0, 1, 0, 0);
        push(1, 0, 0, 1, 0, 16, 1, 1, 0, 0, 0);
        step = 0;
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front(), got);
            want = exp_q.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL next[%0d]: got %p want %p", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_modes;
        sel_v = 2'd0; mode_v = 2'd2;
        push(1, 0, 0, 0, 0, 17, 1, 1, 0, 0, 1);
        push(1, 0, 0, 0, 0, 17, 1, 0, 0, 1, 1);
        push(1, 0, 0, 0, 0, 17, 1, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(0, 1, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        push(1, 0, 0, 0, 0, 1, 0, 1, 0, 0, 1);
        push(1, 0, 0, 0, 0, 2, 0, 1, 0, 0, 1);
        push(1, 0, 0, 0, 0, 3, 0, 1, 0, 0, 1);
        push(1, 0, 0, 0, 0, 3, 0, 0, 0, 1, 1);
        push(1, 0, 0, 0, 0, 3, 0, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 16, 1, 1, 0, 0, 0);
        mode_v = 2'd1;
        push(1, 0, 0, 0, 0, 17, 1, 1, 0, 0, 1);
        push(1, 0, 0, 0, 0, 17, 1, 0, 0, 1, 1);
        push(1, 0, 0, 0, 0, 17, 1, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 16, 1, 1, 0, 0, 0);
        step = 0;
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front(), got);
            want = exp_q.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL modes[%0d]: got %p want %p", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_stop_priority;
        sel_v = 2'd0;
        push(1, 1, 1, 1, 0, 0, 0, 0, 0, 0, 1);
        push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(1, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0);
        step = 0;
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front(), got);
            want = exp_q.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL stop[%0d]: got %p want %p", step, got, want);
            end
            step++;
        end
    endtask

    task automatic test_reset_mid_gap;
        sel_v = 2'd1; mode_v = 2'd3;
        push(0, 0, 0, 0, 0, 16, 1, 0, 0, 0, 0);
        push(0, 1, 0, 0, 0, 16, 1, 1, 0, 0, 0);
        push(1, 0, 0, 0, 0, 17, 1, 1, 0, 0, 1);
        push(1, 0, 0, 0, 0, 17, 1, 0, 0, 1, 1);
        push(1, 0, 0, 0, 0, 17, 1, 0, 0, 0, 0);
        sel_v = 2'd0;
        push(1, 1, 0, 0, 1, 0, 0, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        sel_v = 2'd1;
        push(0, 1, 0, 0, 0, 16, 1, 1, 0, 0, 0);
        push(1, 0, 0, 0, 0, 17, 1, 1, 0, 0, 1);
        push(1, 0, 0, 0, 0, 17, 1, 0, 0, 1, 1);
        push(1, 0, 0, 0, 0, 17, 1, 0, 0, 0, 0);
        push(1, 0, 0, 0, 0, 0, 0, 1, 0, 0, 0);
        step = 0;
        while (stim_q.size() > 0) begin
            apply(stim_q.pop_front(), got);
            want = exp_q.pop_front();
            compared++;
            if (got !== want) begin
                mismatched++;
                $display("FAIL rst_gap[%0d]: got %p want %p", step, got, want);
            end
            step++;
        end
    endtask

    initial begin
        test_reset();
        test_single();
        test_loop();
        test_pause();
        test_next();
        test_modes();
        test_stop_priority();
        test_reset_mid_gap();
        @(negedge clk);
        beat_tick = 1'b0;
        play      = 1'b0;
        stop      = 1'b0;
        next      = 1'b0;
        ext_rst   = 1'b0;
        $display("*** SUMMARY: %0d compared / %0d mismatched ***",
                 compared, mismatched);
        $finish;
    end

endmodule
